// File: rtl/cfg_loader_pkg.sv
// ---------------------------------------------------------------------------
// cfg_loader_pkg
// Purpose : Shared definitions for the configuration loader: the loader FSM
//           state encoding, the largest supported register count and the
//           layout of the peripheral-interface (pi_*) write bus.
// Contents: N_REG_MAX  - upper bound on the number of config registers
//           state_t    - loader FSM states
//           pi_bus_t   - one field per pi_* output of cfg_loader
// ---------------------------------------------------------------------------
package cfg_loader_pkg;

    localparam int N_REG_MAX = 16;

    typedef enum logic [2:0] {
        IDLE,
        WR_SET,
        WR_STB,
        RD_SET,
        RD_CHK,
        FIN
    } state_t;

    // Field order mirrors the pi_* ports: strobe, write qualifier,
    // region select, register index, write data.
    typedef struct packed {
        logic       act;
        logic       we;
        logic       ce_cfg;
        logic [3:0] addr;
        logic [7:0] dato;
    } pi_bus_t;

endpackage

// File: rtl/cfg_loader.sv
// ---------------------------------------------------------------------------
// cfg_loader
// Purpose : Copies a 128-bit configuration image into N_REG byte-wide
//           config registers over the pi_* bus, then optionally reads every
//           register back and compares it against the image.
// Ports   : clk        - system clock, rising edge
//           rst_n      - asynchronous active-low reset
//           start      - one-cycle load request (accepted only in IDLE)
//           abort      - synchronous cancel of a load in progress
//           img        - config image, byte k targets register k
//           pi_act     - bus transaction strobe (write pulses only)
//           pi_we      - write qualifier
//           pi_ce_cfg  - config-register region select
//           pi_addr    - register index
//           pi_dato    - write data
//           pi_di      - read-back data from the responder
//           busy       - load in progress
//           done       - one-cycle pulse on a clean completion
//           err        - sticky read-back mismatch flag
//           err_addr   - index of the first mismatching register
// ---------------------------------------------------------------------------
module cfg_loader
    import cfg_loader_pkg::*;
#(
    parameter int N_REG  = 9,
    parameter bit VERIFY = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [127:0] img,
    output logic         pi_act,
    output logic         pi_we,
    output logic         pi_ce_cfg,
    output logic [3:0]   pi_addr,
    output logic [7:0]   pi_dato,
    input  logic [7:0]   pi_di,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [3:0]   err_addr
);

    localparam logic [3:0] LAST_IDX = 4'(N_REG - 1);

    state_t     state;
    state_t     next_state;
    logic [3:0] idx;
    logic [7:0] shadow [N_REG_MAX];
    logic [7:0] rd_data;
    pi_bus_t    pi;
    logic       load_go;
    logic       last_idx;
    logic       mismatch;

    // abort wins over start so a simultaneous request never begins a load
    assign load_go  = start && !abort;
    assign last_idx = (idx == LAST_IDX);
    assign mismatch = (rd_data != shadow[idx]);

    assign pi_act    = pi.act;
    assign pi_we     = pi.we;
    assign pi_ce_cfg = pi.ce_cfg;
    assign pi_addr   = pi.addr;
    assign pi_dato   = pi.dato;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Bus outputs are decoded from state alone, so reset clears them
    // immediately without waiting for a clock edge.
    always_comb begin
        next_state = state;
        pi         = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (load_go) begin
                    next_state = WR_SET;
                end
            end
            WR_SET: begin
                busy       = 1'b1;
                pi.we      = 1'b1;
                pi.ce_cfg  = 1'b1;
                pi.addr    = idx;
                pi.dato    = shadow[idx];
                next_state = WR_STB;
            end
            WR_STB: begin
                busy       = 1'b1;
                pi.act     = 1'b1;
                pi.we      = 1'b1;
                pi.ce_cfg  = 1'b1;
                pi.addr    = idx;
                pi.dato    = shadow[idx];
                if (!last_idx) begin
                    next_state = WR_SET;
                end else begin
                    next_state = VERIFY ? RD_SET : FIN;
                end
            end
            RD_SET: begin
                busy       = 1'b1;
                pi.ce_cfg  = 1'b1;
                pi.addr    = idx;
                next_state = RD_CHK;
            end
            RD_CHK: begin
                busy      = 1'b1;
                pi.ce_cfg = 1'b1;
                pi.addr   = idx;
                if (mismatch || last_idx) begin
                    next_state = FIN;
                end else begin
                    next_state = RD_SET;
                end
            end
            FIN: begin
                // An abort landing on FIN still counts as a cancelled load.
                done       = !err && !abort;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (abort && (state != IDLE)) begin
            next_state = IDLE;
        end
    end

    // Shadow image, index counter, read-back register and error flags.
    // idx is reloaded to 0 at the end of the write pass so the verify pass
    // starts from register 0; it never steps past LAST_IDX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            rd_data  <= '0;
            err      <= 1'b0;
            err_addr <= '0;
            for (int k = 0; k < N_REG_MAX; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (load_go) begin
                        idx      <= '0;
                        err      <= 1'b0;
                        err_addr <= '0;
                        for (int k = 0; k < N_REG_MAX; k++) begin
                            shadow[k] <= img[8*k +: 8];
                        end
                    end
                end
                WR_STB: begin
                    if (!abort) begin
                        idx <= last_idx ? 4'd0 : idx + 4'd1;
                    end
                end
                RD_SET: begin
                    rd_data <= pi_di;
                end
                RD_CHK: begin
                    if (!abort) begin
                        if (mismatch) begin
                            err      <= 1'b1;
                            err_addr <= idx;
                        end else if (!last_idx) begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/cfg_loader.md
CFG_LOADER -- requirements
Module: cfg_loader

Interface
REQ-001 Parameter N_REG, default 9, number of config registers written, range 1..16, starting at index 0.
REQ-002 Parameter VERIFY, default 1, enables the read-back verify pass after the write pass.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  one-cycle request to load img into the config registers.
REQ-006 abort  in  1  synchronous cancel of any load in progress.
REQ-007 img  in  128  config image; byte k = img[8k+7:8k] targets register k.
REQ-008 pi_act  out  1  bus transaction strobe.
REQ-009 pi_we  out  1  write qualifier.
REQ-010 pi_ce_cfg  out  1  config-register region select.
REQ-011 pi_addr  out  4  register index.
REQ-012 pi_dato  out  8  write data.
REQ-013 pi_di  in  8  read-back data; combinational function of pi_addr at the responder.
REQ-014 busy  out  1  high from the cycle after start is accepted until return to IDLE.
REQ-015 done  out  1  one-cycle pulse when a load completes without mismatch.
REQ-016 err  out  1  sticky mismatch flag; cleared on the next accepted start.
REQ-017 err_addr  out  4  index of the first mismatching register.

Function
REQ-018 FSM states SHALL be IDLE, WR_SET, WR_STB, RD_SET, RD_CHK, FIN.
REQ-019 In IDLE, start=1 with abort=0 SHALL latch img into an internal shadow, clear idx and err, and go to WR_SET; later img changes SHALL have no effect on the load.
REQ-020 WR_SET SHALL drive pi_addr=idx, pi_dato=shadow byte idx, pi_ce_cfg=1, pi_we=1, pi_act=0, then go to WR_STB.
REQ-021 WR_STB SHALL hold addr/data/ce/we and assert pi_act=1 for exactly one cycle; each register therefore takes 2 cycles.
REQ-022 After WR_STB, if idx<N_REG-1 the FSM SHALL increment idx and go to WR_SET; otherwise it SHALL reset idx to 0 and go to RD_SET if VERIFY=1, else to FIN.
REQ-023 RD_SET SHALL drive pi_addr=idx, pi_ce_cfg=1, pi_we=0, pi_act=0, and register pi_di at the end of the cycle.
REQ-024 RD_CHK SHALL compare the registered pi_di with shadow byte idx.
REQ-025 On a mismatch in RD_CHK, the FSM SHALL set err, set err_addr=idx, and go to FIN without pulsing done.
REQ-026 On a match in RD_CHK, the FSM SHALL increment idx and go to RD_SET, or go to FIN after the last index.
REQ-027 FIN SHALL pulse done (only if err=0), deassert busy, and return to IDLE; done SHALL coincide with busy falling.
REQ-028 Fixed latency without errors: 2*N_REG+1 cycles from start to done, plus 2*N_REG cycles when VERIFY=1 (N_REG=9, VERIFY=1: 37 cycles).
REQ-029 start while busy SHALL be ignored.
REQ-030 abort in any non-IDLE state SHALL go to IDLE on the next edge with pi_act=0 and no done; err SHALL be unchanged.
REQ-031 start and abort together in IDLE: abort wins, no load starts.
REQ-032 In IDLE all pi_* outputs SHALL be 0.
REQ-033 pi_act SHALL never be high while pi_we=0.
REQ-034 The index counter SHALL never exceed N_REG-1; there SHALL be no wrap to 0 inside a pass.

Reset
REQ-035 While rst_n=0, the FSM SHALL be in IDLE and all outputs and shadow bytes SHALL be 0, independent of clk.
REQ-036 Reset asserted mid-load SHALL drop pi_act within the same cycle, with no done and no err.
REQ-037 The first accepted start SHALL be on the first rising edge after rst_n deasserts.

Structure
REQ-038 The FSM state enum and N_REG_MAX=16 SHALL live in the shared package.
REQ-039 The pi_* outputs SHALL map one-to-one onto the package PiBus write fields.
REQ-040 The block SHALL be a single module with no sub-module; the shadow is a 16x8 register array.

Verification
REQ-041 Load with img bytes 0..8 = 01,3F,14,80,05,00,00,D3,F0, into a model sys_cfg register file: 9 single-cycle pi_act pulses at addr 0..8, done at cycle 37, model contents equal img.
REQ-042 Responder corrupts register 4 (reads 0x07 instead of 0x05): err=1, err_addr=4, no done, busy falls after the RD_CHK of index 4.
REQ-043 abort at cycle 6: no further pi_act, returns to IDLE, model registers 0..2 written and 3..8 unchanged.
REQ-044 start pulsed again at cycle 10 of a load, and img changed at cycle 3: both have no effect, and the written data equals the img value at start.
REQ-045 rst_n dropped during WR_STB: pi_act falls in the same cycle, all outputs 0, and a fresh load then completes normally.
REQ-046 N_REG=16, VERIFY=0: addr runs 0..15 with no wrap, done at cycle 33.
